// File: rtl/ook_frame_gen.sv
// ---------------------------------------------------------------------------
// ook_frame_gen
// Framed OOK burst generator for the GTP transmit word path (txusrclk2).
// A send request produces: PREAMBLE_WORDS words of 1010..., one SYNC_WORD,
// then frame_len words of PRBS payload of the selected order. A one-deep
// request queue lets a request made mid-frame start the next frame right
// after the current one, with no idle word in between.
//
// Ports
//   clk          : TX user clock (txusrclk2)
//   rst          : synchronous, active-high reset
//   send_enable  : send request, one request per cycle in which it is high
//   prbs_mode    : PRBS order 00:7  01:15  10:23  11:31
//   frame_len    : payload length in words (0 = request discarded)
//   data_out     : registered TX word, MSB transmitted first
//   frame_active : high on every preamble, sync and payload word
//   sof          : high on the first preamble word
//   eof          : high on the last payload word
//   pending      : a queued request is waiting
// ---------------------------------------------------------------------------
module ook_frame_gen #(
    parameter int                DATA_W         = 16,
    parameter int                PREAMBLE_WORDS = 4,
    parameter logic [DATA_W-1:0] SYNC_WORD      = 16'hB4C3,
    parameter int                LEN_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send_enable,
    input  logic [1:0]        prbs_mode,
    input  logic [LEN_W-1:0]  frame_len,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_active,
    output logic              sof,
    output logic              eof,
    output logic              pending
);

    localparam logic [DATA_W-1:0] PREAMBLE_PAT = {(DATA_W/2){2'b10}};
    localparam logic [7:0]        PRE_LAST     = 8'(PREAMBLE_WORDS);
    localparam logic [30:0]       LFSR_SEED    = {31{1'b1}};
    localparam logic [LEN_W-1:0]  LEN_ZERO     = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE      = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_SYNC     = 2'd2,
        ST_PAYLOAD  = 2'd3
    } state_t;

    // One Fibonacci LFSR bit step for the selected order. Only s[n-1:0]
    // shifts; bits above the active order are left untouched.
    // Returns {new_bit, next_state}.
    function automatic logic [31:0] lfsr_step(input logic [30:0] s,
                                              input logic [1:0]  mode);
        logic        new_bit;
        logic [30:0] mask;
        logic [30:0] shifted;
        case (mode)
            2'b00: begin
                new_bit = s[6] ^ s[5];
                mask    = 31'h0000_007F;
            end
            2'b01: begin
                new_bit = s[14] ^ s[13];
                mask    = 31'h0000_7FFF;
            end
            2'b10: begin
                new_bit = s[22] ^ s[17];
                mask    = 31'h007F_FFFF;
            end
            default: begin
                new_bit = s[30] ^ s[27];
                mask    = 31'h7FFF_FFFF;
            end
        endcase
        shifted = {s[29:0], new_bit};
        return {new_bit, (s & ~mask) | (shifted & mask)};
    endfunction

    state_t             r_state;
    logic [7:0]         r_pre_cnt;
    logic [LEN_W-1:0]   r_word_cnt;
    logic [LEN_W-1:0]   r_len;
    logic [1:0]         r_mode;
    logic [30:0]        r_lfsr;
    logic               r_pending;
    logic [DATA_W-1:0]  r_data;
    logic               r_active;
    logic               r_sof;
    logic               r_eof;

    state_t             w_nxt_state;
    logic [7:0]         w_nxt_pre_cnt;
    logic [LEN_W-1:0]   w_nxt_word_cnt;
    logic [LEN_W-1:0]   w_nxt_len;
    logic [1:0]         w_nxt_mode;
    logic [30:0]        w_nxt_lfsr;
    logic               w_nxt_pending;
    logic [DATA_W-1:0]  w_nxt_data;
    logic               w_nxt_active;
    logic               w_nxt_sof;
    logic               w_nxt_eof;

    logic [DATA_W-1:0]  w_prbs_word;
    logic [30:0]        w_prbs_lfsr;
    logic [30:0]        w_lfsr_acc;
    logic [31:0]        w_step;
    logic [LEN_W-1:0]   w_word_cnt_inc;
    logic               w_last_payload;
    logic               w_start;

    assign w_word_cnt_inc = r_word_cnt + LEN_ONE;
    assign w_last_payload = (r_state == ST_PAYLOAD) && (r_word_cnt == r_len);
    // The next frame may start from idle or on the last payload word, which
    // is what gives gap-free back-to-back frames.
    assign w_start = (send_enable | r_pending) &&
                     ((r_state == ST_IDLE) || w_last_payload);

    // Unrolled DATA_W-bit LFSR advance; the first bit lands in the MSB.
    always_comb begin
        w_lfsr_acc  = r_lfsr;
        w_step      = 32'd0;
        w_prbs_word = {DATA_W{1'b0}};
        for (int i = 0; i < DATA_W; i++) begin
            w_step                     = lfsr_step(w_lfsr_acc, r_mode);
            w_prbs_word[DATA_W-1-i]    = w_step[31];
            w_lfsr_acc                 = w_step[30:0];
        end
        w_prbs_lfsr = w_lfsr_acc;
    end

    // Next-state and next-output logic; outputs describe the word shown after the edge.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_pre_cnt  = r_pre_cnt;
        w_nxt_word_cnt = r_word_cnt;
        w_nxt_len      = r_len;
        w_nxt_mode     = r_mode;
        w_nxt_lfsr     = r_lfsr;
        w_nxt_pending  = r_pending;
        w_nxt_data     = {DATA_W{1'b0}};
        w_nxt_active   = 1'b0;
        w_nxt_sof      = 1'b0;
        w_nxt_eof      = 1'b0;

        if (w_start) begin
            // Parameters are captured here; a zero length consumes the request.
            w_nxt_pending = 1'b0;
            w_nxt_len     = frame_len;
            w_nxt_mode    = prbs_mode;
            w_nxt_lfsr    = LFSR_SEED;
            if (frame_len != LEN_ZERO) begin
                w_nxt_state   = ST_PREAMBLE;
                w_nxt_pre_cnt = 8'd1;
                w_nxt_data    = PREAMBLE_PAT;
                w_nxt_active  = 1'b1;
                w_nxt_sof     = 1'b1;
            end else begin
                w_nxt_state   = ST_IDLE;
            end
        end else begin
            // A request while mid-frame queues; a second one is simply dropped.
            if (send_enable && (r_state != ST_IDLE)) begin
                w_nxt_pending = 1'b1;
            end else begin
                w_nxt_pending = r_pending;
            end
            case (r_state)
                ST_IDLE: begin
                    w_nxt_state = ST_IDLE;
                end
                ST_PREAMBLE: begin
                    w_nxt_active = 1'b1;
                    if (r_pre_cnt == PRE_LAST) begin
                        w_nxt_state = ST_SYNC;
                        w_nxt_data  = SYNC_WORD;
                    end else begin
                        w_nxt_pre_cnt = r_pre_cnt + 8'd1;
                        w_nxt_data    = PREAMBLE_PAT;
                    end
                end
                ST_SYNC: begin
                    w_nxt_state    = ST_PAYLOAD;
                    w_nxt_active   = 1'b1;
                    w_nxt_data     = w_prbs_word;
                    w_nxt_lfsr     = w_prbs_lfsr;
                    w_nxt_word_cnt = LEN_ONE;
                    w_nxt_eof      = (r_len == LEN_ONE);
                end
                ST_PAYLOAD: begin
                    if (w_last_payload) begin
                        w_nxt_state = ST_IDLE;
                    end else begin
                        w_nxt_active   = 1'b1;
                        w_nxt_data     = w_prbs_word;
                        w_nxt_lfsr     = w_prbs_lfsr;
                        w_nxt_word_cnt = w_word_cnt_inc;
                        w_nxt_eof      = (w_word_cnt_inc == r_len);
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pre_cnt  <= 8'd0;
            r_word_cnt <= LEN_ZERO;
            r_len      <= LEN_ZERO;
            r_mode     <= 2'b00;
            r_lfsr     <= LFSR_SEED;
            r_pending  <= 1'b0;
            r_data     <= {DATA_W{1'b0}};
            r_active   <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_pre_cnt  <= w_nxt_pre_cnt;
            r_word_cnt <= w_nxt_word_cnt;
            r_len      <= w_nxt_len;
            r_mode     <= w_nxt_mode;
            r_lfsr     <= w_nxt_lfsr;
            r_pending  <= w_nxt_pending;
            r_data     <= w_nxt_data;
            r_active   <= w_nxt_active;
            r_sof      <= w_nxt_sof;
            r_eof      <= w_nxt_eof;
        end
    end

    assign data_out     = r_data;
    assign frame_active = r_active;
    assign sof          = r_sof;
    assign eof          = r_eof;
    assign pending      = r_pending;

endmodule

// File: tb/tb_ook_frame_gen.sv
// ---------------------------------------------------------------------------
// tb_ook_frame_gen
// Self-checking bench for ook_frame_gen with default parameters. A reference
// model holds the words still to be sent of the current frame in a queue:
// an empty queue means the DUT is idle or showing its last payload word,
// which is exactly when a new frame may start. Frames are built from the
// framing rules and a bit-serial reference LFSR.
// ---------------------------------------------------------------------------
module tb_ook_frame_gen;

    typedef struct packed {
        logic [15:0] d;
        logic        sof;
        logic        eof;
        logic        act;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        send_enable;
    logic [1:0]  prbs_mode;
    logic [15:0] frame_len;
    logic [15:0] data_out;
    logic        frame_active;
    logic        sof;
    logic        eof;
    logic        pending;

    int n_checks = 0;
    int n_fail   = 0;

    word_t       mq[$];
    logic        mpend;
    word_t       exp_w;
    logic [15:0] cap[$];
    logic        cap_en;

    int n_sof, n_eof, n_act, n_b2b, cur_words, last_words;
    logic prev_eof;

    always #5 clk = ~clk;

    ook_frame_gen dut (
        .clk          (clk),
        .rst          (rst),
        .send_enable  (send_enable),
        .prbs_mode    (prbs_mode),
        .frame_len    (frame_len),
        .data_out     (data_out),
        .frame_active (frame_active),
        .sof          (sof),
        .eof          (eof),
        .pending      (pending)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, expv);
        end
    endtask

    // Append one complete frame (preamble, sync, payload) to the model queue.
    function automatic void push_frame(input int len, input int mode);
        word_t       w;
        int          n;
        int          t;
        longint      s;
        longint      nb;
        logic [15:0] d;
        for (int i = 0; i < 4; i++) begin
            w.d = 16'hAAAA; w.sof = (i == 0); w.eof = 1'b0; w.act = 1'b1;
            mq.push_back(w);
        end
        w.d = 16'hB4C3; w.sof = 1'b0; w.eof = 1'b0; w.act = 1'b1;
        mq.push_back(w);
        case (mode)
            0:       begin n = 7;  t = 6;  end
            1:       begin n = 15; t = 14; end
            2:       begin n = 23; t = 18; end
            default: begin n = 31; t = 28; end
        endcase
        s = (64'sd1 <<< n) - 64'sd1;
        for (int k = 0; k < len; k++) begin
            d = 16'h0000;
            for (int b = 15; b >= 0; b--) begin
                nb   = ((s >>> (n - 1)) ^ (s >>> (t - 1))) & 64'sd1;
                s    = ((s <<< 1) | nb) & ((64'sd1 <<< n) - 64'sd1);
                d[b] = nb[0];
            end
            w.d = d; w.sof = 1'b0; w.eof = (k == len - 1); w.act = 1'b1;
            mq.push_back(w);
        end
    endfunction

    task automatic reset_stats();
        n_sof = 0; n_eof = 0; n_act = 0; n_b2b = 0;
        cur_words = 0; last_words = 0; prev_eof = 1'b0;
    endtask

    // One clock: update the model from the current inputs, clock, compare.
    task automatic step();
        if (rst) begin
            mq.delete();
            mpend = 1'b0;
            exp_w = '0;
        end else begin
            if ((send_enable || mpend) && (mq.size() == 0)) begin
                mpend = 1'b0;
                if (frame_len != 16'd0) push_frame(int'(frame_len), int'(prbs_mode));
            end else if (send_enable) begin
                mpend = 1'b1;
            end
            if (mq.size() > 0) exp_w = mq.pop_front();
            else               exp_w = '0;
        end
        @(posedge clk);
        @(negedge clk);
        check("data_out",     {48'd0, data_out}, {48'd0, exp_w.d});
        check("sof",          {63'd0, sof},          {63'd0, exp_w.sof});
        check("eof",          {63'd0, eof},          {63'd0, exp_w.eof});
        check("frame_active", {63'd0, frame_active}, {63'd0, exp_w.act});
        check("pending",      {63'd0, pending},      {63'd0, mpend});
        if (frame_active === 1'b1) n_act++;
        if (sof === 1'b1) begin
            n_sof++;
            if (prev_eof) n_b2b++;
            cur_words = 0;
        end
        if (frame_active === 1'b1) cur_words++;
        if (eof === 1'b1) begin
            n_eof++;
            last_words = cur_words;
        end
        prev_eof = (eof === 1'b1);
        if (cap_en && frame_active === 1'b1) cap.push_back(data_out);
    endtask

    task automatic pulse(input logic [15:0] len, input logic [1:0] mode);
        frame_len = len; prbs_mode = mode; send_enable = 1'b1;
        step();
        send_enable = 1'b0;
    endtask

    task automatic run_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (mq.size() == 0 && !mpend && frame_active === 1'b0) break;
            step();
        end
        check("idle_reached", {63'd0, frame_active}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; send_enable = 1'b0; frame_len = 16'd0; prbs_mode = 2'b00;
        mpend = 1'b0; cap_en = 1'b0;
        reset_stats();

        // Reset state
        step(); step();
        rst = 1'b0;
        step();

        // Basic frame: len 3, PRBS7
        reset_stats();
        pulse(16'd3, 2'b00);
        check("t1_sof_latency", {63'd0, sof}, 64'd1);
        check("t1_first_pre", {48'd0, data_out}, 64'hAAAA);
        for (int i = 0; i < 5; i++) step();
        check("t1_first_payload", {48'd0, data_out}, 64'h020C);
        for (int i = 0; i < 6; i++) step();
        check("t1_active_cycles", n_act, 64'd8);
        check("t1_eof_count", n_eof, 64'd1);
        check("t1_data_after", {48'd0, data_out}, 64'd0);

        // PRBS streams, 1000 words in each mode
        for (int m = 0; m < 4; m++) begin
            reset_stats();
            cap.delete();
            cap_en = 1'b1;
            pulse(16'd1000, 2'(m));
            run_idle(1200);
            cap_en = 1'b0;
            check("prbs_words", cap.size(), 64'd1005);
            if (m == 0 && cap.size() == 1005) begin
                int          mism;
                logic [15:0] wa;
                logic [15:0] wb;
                mism = 0;
                for (int k = 0; k + 127 < 16000; k++) begin
                    wa = cap[5 + k / 16];
                    wb = cap[5 + (k + 127) / 16];
                    if (wa[15 - (k % 16)] !== wb[15 - ((k + 127) % 16)]) mism++;
                end
                check("prbs7_period127", mism, 64'd0);
            end
        end

        // Queue: request mid-payload, third request dropped, new length
        reset_stats();
        pulse(16'd5, 2'b01);
        for (int i = 0; i < 5; i++) step();
        send_enable = 1'b1; step(); send_enable = 1'b0;
        check("q_pending_set", {63'd0, pending}, 64'd1);
        send_enable = 1'b1; step(); send_enable = 1'b0;
        frame_len = 16'd4;
        run_idle(100);
        check("q_frames", n_sof, 64'd2);
        check("q_back_to_back", n_b2b, 64'd1);
        check("q_frame2_words", last_words, 64'd9);

        // Zero length request
        reset_stats();
        pulse(16'd0, 2'b10);
        for (int i = 0; i < 4; i++) step();
        check("z_no_sof", n_sof, 64'd0);
        check("z_no_active", n_act, 64'd0);
        check("z_no_pending", {63'd0, pending}, 64'd0);

        // Reset during sync word
        reset_stats();
        pulse(16'd3, 2'b00);
        for (int i = 0; i < 4; i++) step();
        check("r_in_sync", {48'd0, data_out}, 64'hB4C3);
        rst = 1'b1; step(); rst = 1'b0;
        check("r_data_zero", {48'd0, data_out}, 64'd0);
        check("r_active_zero", {63'd0, frame_active}, 64'd0);
        check("r_eof_zero", n_eof, 64'd0);
        pulse(16'd3, 2'b00);
        for (int i = 0; i < 5; i++) step();
        check("r_first_payload", {48'd0, data_out}, 64'h020C);
        run_idle(50);

        // Level request held for 20 cycles, len 2
        reset_stats();
        frame_len = 16'd2; prbs_mode = 2'b11; send_enable = 1'b1;
        for (int i = 0; i < 20; i++) step();
        send_enable = 1'b0;
        run_idle(50);
        check("h_frames", n_sof, 64'd4);
        check("h_active", n_act, 64'd28);
        check("h_back_to_back", n_b2b, 64'd3);
        check("h_last_words", last_words, 64'd7);

        // Random traffic against the model
        reset_stats();
        for (int i = 0; i < 1500; i++) begin
            send_enable = ($urandom_range(0, 7) == 0);
            frame_len   = 16'($urandom_range(0, 6));
            prbs_mode   = 2'($urandom_range(0, 3));
            rst         = ($urandom_range(0, 249) == 0);
            step();
        end
        rst = 1'b0; send_enable = 1'b0;
        run_idle(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
